p2s_serializer: RTL and testbench



---
 rtl/p2s_pkg.sv | 21 ++
 rtl/p2s_lane.sv | 53 +++++
 rtl/p2s_serializer.sv | 199 +++++++++++++++++++
 tb/tb_p2s_serializer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// ---------------------------------------------------------------------------
// p2s_pkg -- shared definitions for the parallel-to-serial serializer.
//
// Contents:
//   p2s_state_e  : serializer FSM states (P2S_IDLE, P2S_SHIFT)
//   P2S_DATA_W   : default bits per channel word
//   P2S_NUM_CH   : default channel count (0 = left, 1 = right)
//   P2S_BIDX_W   : default width of the bit index output
// ---------------------------------------------------------------------------
package p2s_pkg;

  typedef enum logic {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

  localparam int P2S_DATA_W = 40;
  localparam int P2S_NUM_CH = 2;
  localparam int P2S_BIDX_W = 6;

endpackage

// File: rtl/p2s_lane.sv
// ---------------------------------------------------------------------------
// p2s_lane -- one channel's shift register and serial bit select.
//
// The lane captures its channel word on load and then shifts one bit per
// clock in the direction chosen by lsb_first. The presented bit is always
// the end of the register that leaves first, so no index arithmetic is
// needed per lane.
//
// Ports:
//   clk        in   bit clock
//   srst       in   synchronous active-high reset (clears the register)
//   load       in   capture word into the shift register
//   shift      in   advance to the next bit
//   lsb_first  in   1 = LSB leaves first, 0 = MSB leaves first
//   active     in   lane is presenting a valid bit (else output forced 0)
//   word       in   DATA_W-bit channel word
//   bit_out    out  serial bit for this channel
// ---------------------------------------------------------------------------
module p2s_lane
  import p2s_pkg::*;
#(
  parameter int DATA_W = P2S_DATA_W
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              shift,
  input  logic              lsb_first,
  input  logic              active,
  input  logic [DATA_W-1:0] word,
  output logic              bit_out
);

  logic [DATA_W-1:0] sh_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sh_reg <= '0;
    end else if (load) begin
      sh_reg <= word;
    end else if (shift) begin
      if (lsb_first) begin
        sh_reg <= {1'b0, sh_reg[DATA_W-1:1]};
      end else begin
        sh_reg <= {sh_reg[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Idle lanes drive zero regardless of what is left in the register.
  assign bit_out = active & (lsb_first ? sh_reg[0] : sh_reg[DATA_W-1]);

endmodule

// File: rtl/p2s_serializer.sv
// ---------------------------------------------------------------------------
// p2s_serializer -- multi-channel parallel-to-serial converter.
//
// A single holding buffer accepts NUM_CH channel words with a valid/ready
// handshake. A Frame strobe moves the buffer into the per-lane shift
// registers and DATA_W bits are then presented per channel, one per Sclk.
// A Frame on the last bit of a word reloads with no gap.
//
// Optional feature: define P2S_UNDERRUN_EN to build the sticky Underrun
// detector (a Frame arriving while the buffer is empty). Without it,
// Underrun is tied low.
//
// Ports:
//   Sclk        in   serial bit clock (sole clock)
//   Reset       in   synchronous active-high reset
//   Frame       in   frame-start strobe, one Sclk cycle
//   InValid     in   parallel word offered
//   InReady     out  holding buffer can accept a word
//   Outputdata  in   channel words, channel c at [c*DATA_W +: DATA_W]
//   LsbFirst    in   bit order (1 = LSB first), sampled at frame load
//   SerialOut   out  one serial bit per channel
//   OutReady    out  SerialOut holds a valid bit
//   BitIdx      out  index of the bit on SerialOut, all-ones when idle
//   Underrun    out  sticky empty-buffer Frame flag
// ---------------------------------------------------------------------------
module p2s_serializer
  import p2s_pkg::*;
#(
  parameter int DATA_W = P2S_DATA_W,
  parameter int NUM_CH = P2S_NUM_CH,
  parameter int BIDX_W = P2S_BIDX_W
) (
  input  logic                     Sclk,
  input  logic                     Reset,
  input  logic                     Frame,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [NUM_CH*DATA_W-1:0] Outputdata,
  input  logic                     LsbFirst,
  output logic [NUM_CH-1:0]        SerialOut,
  output logic                     OutReady,
  output logic [BIDX_W-1:0]        BitIdx,
  output logic                     Underrun
);

  localparam int WORD_W = NUM_CH * DATA_W;
  localparam logic [BIDX_W-1:0] LAST_CNT = BIDX_W'(DATA_W - 1);

  p2s_state_e        state_reg, state_next;
  logic [BIDX_W-1:0] cnt_reg,   cnt_next;
  logic              lsb_reg,   lsb_next;
  logic [WORD_W-1:0] buf_reg,   buf_next;
  logic              full_reg,  full_next;

  logic last_bit;
  logic frame_window;
  logic load;
  logic shift_en;
  logic accept;

  // A Frame is only acted on in IDLE or on the final bit of a word; in the
  // middle of a word it is ignored so the current word completes intact.
  assign last_bit     = (state_reg == P2S_SHIFT) && (cnt_reg == LAST_CNT);
  assign frame_window = (state_reg == P2S_IDLE) || last_bit;
  assign load         = Frame && full_reg && frame_window;

  // The buffer frees up in the same cycle it is loaded, so a new word can
  // be accepted while the previous one moves into the shift registers.
  assign InReady = !full_reg || load;
  assign accept  = InValid && InReady;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge Sclk) begin
    if (Reset) begin
      state_reg <= P2S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state, bit counter and shift control
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lsb_next   = lsb_reg;
    shift_en   = 1'b0;

    case (state_reg)
      P2S_IDLE: begin
        if (load) begin
          state_next = P2S_SHIFT;
          cnt_next   = '0;
          lsb_next   = LsbFirst;
        end
      end

      P2S_SHIFT: begin
        if (last_bit) begin
          if (load) begin
            // Seamless reload: next word's first bit follows directly.
            cnt_next = '0;
            lsb_next = LsbFirst;
          end else begin
            state_next = P2S_IDLE;
            cnt_next   = '0;
          end
        end else begin
          shift_en = 1'b1;
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = P2S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Holding buffer
  // -------------------------------------------------------------------------
  always_comb begin
    buf_next  = buf_reg;
    full_next = full_reg;
    if (accept) begin
      buf_next  = Outputdata;
      full_next = 1'b1;
    end else if (load) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge Sclk) begin
    if (Reset) begin
      cnt_reg  <= '0;
      lsb_reg  <= 1'b0;
      buf_reg  <= '0;
      full_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      lsb_reg  <= lsb_next;
      buf_reg  <= buf_next;
      full_reg <= full_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign OutReady = (state_reg == P2S_SHIFT);

  // The counter always runs upward; BitIdx mirrors it for MSB-first order.
  always_comb begin
    BitIdx = '1;
    if (OutReady) begin
      BitIdx = lsb_reg ? cnt_reg : (LAST_CNT - cnt_reg);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      p2s_lane #(
        .DATA_W (DATA_W)
      ) u_lane (
        .clk       (Sclk),
        .srst      (Reset),
        .load      (load),
        .shift     (shift_en),
        .lsb_first (lsb_reg),
        .active    (OutReady),
        .word      (buf_reg[gi*DATA_W +: DATA_W]),
        .bit_out   (SerialOut[gi])
      );
    end
  endgenerate

`ifdef P2S_UNDERRUN_EN
  // An empty-buffer Frame in the frame window means a frame was missed.
  logic underrun_reg;

  always_ff @(posedge Sclk) begin
    if (Reset) begin
      underrun_reg <= 1'b0;
    end else if (Frame && !full_reg && frame_window) begin
      underrun_reg <= 1'b1;
    end
  end

  assign Underrun = underrun_reg;
`else
  assign Underrun = 1'b0;
`endif

endmodule

// File: tb/tb_p2s_serializer.sv
// ---------------------------------------------------------------------------
// tb_p2s_serializer -- scoreboard bench for p2s_serializer.
//
// The driver applies one input vector per clock and updates a small
// behavioural model (pending word, bits remaining in the current word).
// Whenever the model predicts a frame load it pushes every expected
// {SerialOut, BitIdx} pair of that word into a queue. A monitor on the
// falling edge pops and compares whenever OutReady is high, and checks the
// idle output pattern otherwise. A second instance covers a 24-bit,
// four-channel build.
// ---------------------------------------------------------------------------
module tb_p2s_serializer;
  import p2s_pkg::*;

  localparam int DW = P2S_DATA_W;
  localparam int NC = P2S_NUM_CH;
  localparam int BW = P2S_BIDX_W;
  localparam int WW = DW * NC;

  localparam int DW2 = 24;
  localparam int NC2 = 4;
  localparam int BW2 = 5;

  logic Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  logic          Reset, Frame, InValid, LsbFirst, InReady, OutReady, Underrun;
  logic [WW-1:0] Outputdata;
  logic [NC-1:0] SerialOut;
  logic [BW-1:0] BitIdx;

  p2s_serializer #(.DATA_W(DW), .NUM_CH(NC), .BIDX_W(BW)) dut (
    .Sclk       (Sclk),
    .Reset      (Reset),
    .Frame      (Frame),
    .InValid    (InValid),
    .InReady    (InReady),
    .Outputdata (Outputdata),
    .LsbFirst   (LsbFirst),
    .SerialOut  (SerialOut),
    .OutReady   (OutReady),
    .BitIdx     (BitIdx),
    .Underrun   (Underrun)
  );

  logic                s2_reset, s2_frame, s2_valid, s2_lsb, s2_in_ready, s2_out_ready, s2_underrun;
  logic [NC2*DW2-1:0]  s2_data;
  logic [NC2-1:0]      s2_serial;
  logic [BW2-1:0]      s2_idx;

  p2s_serializer #(.DATA_W(DW2), .NUM_CH(NC2), .BIDX_W(BW2)) dut2 (
    .Sclk       (Sclk),
    .Reset      (s2_reset),
    .Frame      (s2_frame),
    .InValid    (s2_valid),
    .InReady    (s2_in_ready),
    .Outputdata (s2_data),
    .LsbFirst   (s2_lsb),
    .SerialOut  (s2_serial),
    .OutReady   (s2_out_ready),
    .BitIdx     (s2_idx),
    .Underrun   (s2_underrun)
  );

  typedef struct packed {
    logic [NC-1:0] bits;
    logic [BW-1:0] idx;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  logic          pend_valid;
  logic [WW-1:0] pend_word;
  int            rem;
  logic          und_exp;
  bit            mon_en = 1'b0;
  int            run_len = 0;
  int            max_run = 0;

  // Expected bit stream of one word, straight from the bit-order rule.
  task automatic push_word(input logic [WW-1:0] w, input logic lsb);
    for (int k = 0; k < DW; k++) begin
      exp_t e;
      int   pos;
      pos = lsb ? k : DW - 1 - k;
      for (int c = 0; c < NC; c++) e.bits[c] = w[c*DW + pos];
      e.idx = BW'(pos);
      exp_q.push_back(e);
    end
  endtask

  // Called just after a rising edge: drive one vector, check InReady,
  // then advance the model across the next rising edge.
  task automatic step(input logic rst, input logic frm, input logic vld,
                      input logic lsb, input logic [WW-1:0] data);
    logic exp_ready, load, accept;
    Reset = rst; Frame = frm; InValid = vld; LsbFirst = lsb; Outputdata = data;
    #2;
    load      = frm && pend_valid && (rem <= 1);
    exp_ready = !pend_valid || load;
    if (!rst) begin
      n_cmp++;
      if (InReady !== exp_ready) begin
        n_err++;
        $display("FAIL in_ready: got %b want %b at %0t", InReady, exp_ready, $time);
      end
    end
    @(posedge Sclk); #1;
    if (rst) begin
      exp_q.delete();
      pend_valid = 1'b0;
      rem        = 0;
      und_exp    = 1'b0;
    end else begin
      accept = vld && exp_ready;
`ifdef P2S_UNDERRUN_EN
      if (frm && !pend_valid && (rem <= 1)) und_exp = 1'b1;
`endif
      if (load) begin
        push_word(pend_word, lsb);
        rem        = DW;
        pend_valid = 1'b0;
      end else if (rem > 0) begin
        rem--;
      end
      if (accept) begin
        pend_valid = 1'b1;
        pend_word  = data;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic run_to_last();
    for (int i = 0; i < DW + 2 && rem != 1; i++) idle();
    if (rem != 1) begin
      n_err++;
      $display("FAIL last_bit_timeout: rem %0d want 1", rem);
    end
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [WW-1:0] w;
    for (int i = 0; i < WW; i++) w[i] = 1'($urandom_range(1));
    return w;
  endfunction

  // Monitor: scoreboard pop on every valid bit, idle pattern otherwise.
  always @(negedge Sclk) begin
    if (mon_en) begin
      if (OutReady === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_bit: got out=%b idx=%0d want no output at %0t", SerialOut, BitIdx, $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (SerialOut !== mon_e.bits || BitIdx !== mon_e.idx) begin
            n_err++;
            $display("FAIL serial_bit: got out=%b idx=%0d want out=%b idx=%0d at %0t",
                     SerialOut, BitIdx, mon_e.bits, mon_e.idx, $time);
          end
        end
      end else begin
        run_len = 0;
        n_cmp++;
        if (OutReady !== 1'b0 || SerialOut !== '0 || BitIdx !== '1 || exp_q.size() != 0) begin
          n_err++;
          $display("FAIL idle_out: got rdy=%b out=%b idx=%h pending=%0d want rdy=0 out=0 idx=all-ones pending=0 at %0t",
                   OutReady, SerialOut, BitIdx, exp_q.size(), $time);
        end
      end
      n_cmp++;
      if (Underrun !== und_exp) begin
        n_err++;
        $display("FAIL underrun: got %b want %b at %0t", Underrun, und_exp, $time);
      end
    end
  end

  initial begin
    logic [DW2-1:0] w24;
    logic [NC2-1:0] exp_bits;
    logic           frm;

    Reset = 1'b1; Frame = 1'b0; InValid = 1'b0; LsbFirst = 1'b0; Outputdata = '0;
    pend_valid = 1'b0; pend_word = '0; rem = 0; und_exp = 1'b0;
    s2_reset = 1'b1; s2_frame = 1'b0; s2_valid = 1'b0; s2_lsb = 1'b0; s2_data = '0;

    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    mon_en = 1'b1;
    idle();

    // Known pattern, MSB first: first 01 at idx 39, last 11 at idx 0.
    step(1'b0, 1'b0, 1'b1, 1'b0, {40'h00_0000_0003, 40'h80_0000_0001});
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (DW + 2) idle();

    // Back-to-back: second word buffered mid-shift, Frame on last bit.
    max_run = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0, rnd_word());
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (5) idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, rnd_word());
    run_to_last();
    step(1'b0, 1'b1, 1'b0, 1'b1, '0);
    idle();
    repeat (DW + 2) idle();
    n_cmp++;
    if (max_run != 2 * DW) begin
      n_err++;
      $display("FAIL b2b_run: got %0d want %0d consecutive OutReady cycles", max_run, 2 * DW);
    end

    // LSB first, L = 1: first bit 1 at idx 0, ends at idx 39.
    step(1'b0, 1'b0, 1'b1, 1'b0, {40'h0, 40'h1});
    step(1'b0, 1'b1, 1'b0, 1'b1, '0);
    repeat (DW + 2) idle();

    // Empty-buffer Frame with a word offered in the same cycle; the word
    // waits for the following Frame.
    step(1'b0, 1'b1, 1'b1, 1'b0, rnd_word());
    repeat (3) idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (DW + 2) idle();

    // Reset 20 bits into a word.
    step(1'b0, 1'b0, 1'b1, 1'b0, rnd_word());
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (20) idle();
    step(1'b1, 1'b1, 1'b1, 1'b0, rnd_word());
    idle();
    idle();

    // Randomised traffic, Frame biased toward the last-bit cycle.
    for (int i = 0; i < 3000; i++) begin
      frm = (rem == 1) ? ($urandom_range(3) != 0) : ($urandom_range(11) == 0);
      step(1'($urandom_range(599) == 0), frm, 1'($urandom_range(1)),
           1'($urandom_range(1)), rnd_word());
    end
    repeat (DW + 4) idle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d bits outstanding want 0", exp_q.size());
    end

    // 24-bit, four-channel build: every lane carries the same stream.
    w24 = 24'hA5A5A5;
    s2_reset = 1'b0;
    s2_valid = 1'b1;
    s2_data  = {NC2{w24}};
    @(posedge Sclk); #1;
    s2_valid = 1'b0;
    s2_frame = 1'b1;
    @(posedge Sclk); #1;
    s2_frame = 1'b0;
    for (int k = 0; k < DW2; k++) begin
      @(negedge Sclk);
      exp_bits = {NC2{w24[DW2-1-k]}};
      n_cmp++;
      if (s2_out_ready !== 1'b1 || s2_serial !== exp_bits || s2_idx !== BW2'(DW2 - 1 - k)) begin
        n_err++;
        $display("FAIL sweep_bit%0d: got rdy=%b out=%b idx=%0d want rdy=1 out=%b idx=%0d",
                 k, s2_out_ready, s2_serial, s2_idx, exp_bits, DW2 - 1 - k);
      end
    end
    @(negedge Sclk);
    n_cmp++;
    if (s2_out_ready !== 1'b0 || s2_serial !== '0) begin
      n_err++;
      $display("FAIL sweep_end: got rdy=%b out=%b want rdy=0 out=0", s2_out_ready, s2_serial);
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
